// File: rtl/key_event_decoder.sv
// Classifies debounced key presses: short, long, auto-repeat, double click.
// Define KEY_DOUBLE_CLICK_EN to build the double-click window states.
module key_event_decoder #(
    parameter int unsigned      CNT_W        = 16,
    parameter logic [CNT_W-1:0] PRESCALE     = 16'd1000,
    parameter logic [CNT_W-1:0] LONG_TICKS   = 16'd500,
    parameter logic [CNT_W-1:0] REPEAT_TICKS = 16'd100,
    parameter logic [CNT_W-1:0] DBL_TICKS    = 16'd250
) (
    input  logic clk,
    input  logic resetN,
    input  logic keyLevel,
    output logic shortPress,
    output logic longPress,
    output logic repeatPulse,
    output logic doubleClick,
    output logic keyHeld
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PRE_LAST  = PRESCALE - ONE;
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_TICKS - ONE;
    localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_TICKS - ONE;

    if (PRESCALE == '0 || LONG_TICKS == '0 ||
        REPEAT_TICKS == '0 || DBL_TICKS == '0) begin : g_bad_param
        $error("key_event_decoder: tick parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
`ifdef KEY_DOUBLE_CLICK_EN
        WAIT_SECOND,
        SECOND_PRESSED,
`endif
        LONG_HELD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             key_q;
    logic             key_qd;
    logic             armed;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] hold_cnt;
    logic             tick;
    logic             rise;
    logic             fall;
    logic             long_hit;
    logic             rep_hit;
    logic             short_d;
    logic             long_d;
    logic             rep_d;
    logic             held_nxt;
`ifdef KEY_DOUBLE_CLICK_EN
    logic             dbl_hit;
    logic             dbl_d;
`endif

    assign tick     = (presc == PRE_LAST);
    assign rise     = key_q & ~key_qd;
    assign fall     = ~key_q & key_qd;
    assign long_hit = tick && (hold_cnt == LONG_LAST);
    assign rep_hit  = tick && (hold_cnt == REP_LAST);
`ifdef KEY_DOUBLE_CLICK_EN
    assign dbl_hit  = tick && (hold_cnt == DBL_TICKS - ONE);
`endif

    // armed follows the raw level so the cleared key_q after reset cannot arm
    always_ff @(posedge clk) begin
        if (!resetN) begin
            key_q  <= 1'b0;
            key_qd <= 1'b0;
            armed  <= 1'b0;
            presc  <= '0;
        end else begin
            key_q  <= keyLevel;
            key_qd <= key_q;
            armed  <= armed | ~keyLevel;
            presc  <= tick ? '0 : presc + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            hold_cnt <= '0;
        end else if (state_nxt != state || rep_d) begin
            hold_cnt <= '0;
        end else if (tick && hold_cnt != '1) begin
            hold_cnt <= hold_cnt + ONE;
        end
    end

    // key edges take priority over tick thresholds in every state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise && armed) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (fall) begin
`ifdef KEY_DOUBLE_CLICK_EN
                    state_nxt = WAIT_SECOND;
`else
                    state_nxt = IDLE;
`endif
                end else if (long_hit) begin
                    state_nxt = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall) state_nxt = IDLE;
            end
`ifdef KEY_DOUBLE_CLICK_EN
            WAIT_SECOND: begin
                if (rise) state_nxt = SECOND_PRESSED;
                else if (dbl_hit) state_nxt = IDLE;
            end
            SECOND_PRESSED: begin
                if (fall) state_nxt = IDLE;
                else if (long_hit) state_nxt = LONG_HELD;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
        dbl_d   = 1'b0;
`endif
        case (state)
            PRESSED: begin
                if (!fall && long_hit) long_d = 1'b1;
`ifndef KEY_DOUBLE_CLICK_EN
                if (fall) short_d = 1'b1;
`endif
            end
            LONG_HELD: begin
                if (!fall && rep_hit) rep_d = 1'b1;
            end
`ifdef KEY_DOUBLE_CLICK_EN
            WAIT_SECOND: begin
                if (!rise && dbl_hit) short_d = 1'b1;
            end
            SECOND_PRESSED: begin
                if (fall) dbl_d = 1'b1;
                else if (long_hit) long_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        held_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD);
`ifdef KEY_DOUBLE_CLICK_EN
        held_nxt = held_nxt || (state_nxt == SECOND_PRESSED);
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            shortPress  <= 1'b0;
            longPress   <= 1'b0;
            repeatPulse <= 1'b0;
            keyHeld     <= 1'b0;
        end else begin
            shortPress  <= short_d;
            longPress   <= long_d;
            repeatPulse <= rep_d;
            keyHeld     <= held_nxt;
        end
    end

`ifdef KEY_DOUBLE_CLICK_EN
    always_ff @(posedge clk) begin
        if (!resetN) begin
            doubleClick <= 1'b0;
        end else begin
            doubleClick <= dbl_d;
        end
    end
`else
    assign doubleClick = 1'b0;
`endif

endmodule
